// File: rtl/grad_seq_player_pkg.sv
// grad_seq_player_pkg: shared constants and types for the gradient sample player.
// State encoding, sample layout and BRAM timing live here.
package grad_seq_player_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_WAIT_READY = 3'd2;
    localparam logic [2:0] ST_WAIT_TICK  = 3'd3;
    localparam logic [2:0] ST_WAIT_BUSY  = 3'd4;

    localparam int SAMPLE_WORDS = 4;
    localparam int END_BIT      = 31;
    localparam int MIN_INTERVAL = 8;
    localparam int BRAM_LAT     = 2;

    typedef struct packed {
        logic        last;
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
        logic [23:0] z2;
    } sample_t;

endpackage

// File: rtl/grad_sample_fetch.sv
// grad_sample_fetch: issues the four BRAM reads of one sample and assembles
// the returned words into a shadow sample with a full flag.
module grad_sample_fetch
    import grad_seq_player_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_i,
    input  logic              first_i,
    input  logic              abort_i,
    input  logic              take_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              bram_en_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [31:0]       bram_data_i,
    output logic              issue_done_o,
    output logic              cap_last_o,
    output logic              full_o,
    output sample_t           sample_o
);

    logic                en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [1:0]          rd_idx_q;
    logic [BRAM_LAT-1:0] lat_q;
    logic [1:0]          cap_idx_q;
    logic                full_q;
    sample_t             shadow_q;

    logic [ADDR_W-1:0] fetch_addr;
    logic              rvalid;
    logic              unused_bits;

    assign fetch_addr = first_i ? (base_addr_i & ~ADDR_W'(SAMPLE_WORDS - 1))
                                : ptr_q;
    assign rvalid      = lat_q[BRAM_LAT-1];
    assign unused_bits = ^bram_data_i[END_BIT-1:24];

    assign bram_en_o    = en_q;
    assign bram_addr_o  = addr_q;
    assign issue_done_o = en_q && (rd_idx_q == 2'd3);
    assign cap_last_o   = rvalid && (cap_idx_q == 2'd3);
    assign full_o       = full_q;
    assign sample_o     = shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            addr_q   <= '0;
            ptr_q    <= '0;
            rd_idx_q <= '0;
        end else if (abort_i) begin
            en_q     <= 1'b0;
            rd_idx_q <= '0;
        end else if (fetch_i) begin
            en_q     <= 1'b1;
            addr_q   <= fetch_addr;
            rd_idx_q <= '0;
            ptr_q    <= fetch_addr + ADDR_W'(SAMPLE_WORDS);
        end else if (en_q) begin
            if (rd_idx_q == 2'd3) begin
                en_q <= 1'b0;
            end else begin
                addr_q   <= addr_q + ADDR_W'(1);
                rd_idx_q <= rd_idx_q + 2'd1;
            end
        end
    end

    // Read-return tracking: an abort drops any words still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q     <= '0;
            cap_idx_q <= '0;
        end else if (abort_i) begin
            lat_q     <= '0;
            cap_idx_q <= '0;
        end else begin
            lat_q <= {lat_q[BRAM_LAT-2:0], en_q};
            if (fetch_i) begin
                cap_idx_q <= '0;
            end else if (rvalid) begin
                cap_idx_q <= cap_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (rvalid && !abort_i) begin
            unique case (cap_idx_q)
                2'd0: shadow_q.x <= bram_data_i[23:0];
                2'd1: shadow_q.y <= bram_data_i[23:0];
                2'd2: shadow_q.z <= bram_data_i[23:0];
                2'd3: begin
                    shadow_q.z2   <= bram_data_i[23:0];
                    shadow_q.last <= bram_data_i[END_BIT];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (abort_i || take_i) begin
            full_q <= 1'b0;
        end else if (cap_last_o) begin
            full_q <= 1'b1;
        end
    end

endmodule

// File: rtl/grad_seq_player.sv
// grad_seq_player: plays four-channel gradient samples from BRAM to the
// SPI interface at a programmed interval, flagging busy-induced late updates.
module grad_seq_player
    import grad_seq_player_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    output logic                  bram_en_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    input  logic [31:0]           bram_data_i,
    output logic [23:0]           datax_o,
    output logic [23:0]           datay_o,
    output logic [23:0]           dataz_o,
    output logic [23:0]           dataz2_o,
    output logic                  valid_o,
    input  logic                  busy_i,
    output logic                  running_o,
    output logic                  underrun_o,
    output logic [INTERVAL_W-1:0] sample_cnt_o
);

    logic [2:0]            state_q, state_d;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic                  under_q, under_d;
    logic [INTERVAL_W-1:0] scnt_q, scnt_d;
    logic [23:0]           x_q, y_q, z_q, z2_q;

    logic                  start_ok;
    logic                  tick_zero;
    logic                  issue;
    logic                  fetch_go;
    logic                  issue_done;
    logic                  cap_last;
    logic                  full;
    sample_t               shadow;
    logic [INTERVAL_W-1:0] iv_eff;
    logic [INTERVAL_W-1:0] reload;
    logic                  counting;

    grad_sample_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk          (clk),
        .rst          (rst),
        .fetch_i      (fetch_go),
        .first_i      (start_ok),
        .abort_i      (stop_i),
        .take_i       (issue),
        .base_addr_i  (base_addr_i),
        .bram_en_o    (bram_en_o),
        .bram_addr_o  (bram_addr_o),
        .bram_data_i  (bram_data_i),
        .issue_done_o (issue_done),
        .cap_last_o   (cap_last),
        .full_o       (full),
        .sample_o     (shadow)
    );

    assign start_ok  = (state_q == ST_IDLE) && start_i && !stop_i;
    assign tick_zero = (cnt_q == '0);
    assign issue     = !stop_i && full && !busy_i &&
                       ((state_q == ST_WAIT_BUSY) ||
                        ((state_q == ST_WAIT_TICK) && tick_zero));
    assign fetch_go  = start_ok || (issue && !shadow.last);

    assign iv_eff = (interval_i < INTERVAL_W'(MIN_INTERVAL))
                  ? INTERVAL_W'(MIN_INTERVAL) : interval_i;
    assign reload = iv_eff - INTERVAL_W'(1);

    // The interval runs through the prefetch so expiry lands exactly on time.
    assign counting = (state_q == ST_FETCH) || (state_q == ST_WAIT_READY) ||
                      (state_q == ST_WAIT_TICK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        under_d = under_q;
        scnt_d  = scnt_q;
        if (counting && !tick_zero) begin
            cnt_d = cnt_q - INTERVAL_W'(1);
        end
        if (issue) begin
            cnt_d   = reload;
            scnt_d  = scnt_q + INTERVAL_W'(1);
            first_d = 1'b0;
        end
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (start_ok) begin
                    state_d = ST_FETCH;
                    under_d = 1'b0;
                    scnt_d  = '0;
                    first_d = 1'b1;
                end
            end
            (state_q == ST_FETCH): begin
                if (issue_done) state_d = ST_WAIT_READY;
            end
            (state_q == ST_WAIT_READY): begin
                if (cap_last) state_d = first_q ? ST_WAIT_BUSY : ST_WAIT_TICK;
            end
            (state_q == ST_WAIT_TICK): begin
                if (issue) begin
                    state_d = shadow.last ? ST_IDLE : ST_FETCH;
                end else if (tick_zero && busy_i && !stop_i) begin
                    under_d = 1'b1;
                    state_d = ST_WAIT_BUSY;
                end
            end
            (state_q == ST_WAIT_BUSY): begin
                if (issue) state_d = shadow.last ? ST_IDLE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            under_q <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            under_q <= under_d;
            scnt_q  <= scnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            z_q  <= '0;
            z2_q <= '0;
        end else if (issue) begin
            x_q  <= shadow.x;
            y_q  <= shadow.y;
            z_q  <= shadow.z;
            z2_q <= shadow.z2;
        end
    end

    // New data is presented alongside its valid pulse, then held.
    assign datax_o  = issue ? shadow.x  : x_q;
    assign datay_o  = issue ? shadow.y  : y_q;
    assign dataz_o  = issue ? shadow.z  : z_q;
    assign dataz2_o = issue ? shadow.z2 : z2_q;

    assign valid_o      = issue;
    assign running_o    = (state_q != ST_IDLE);
    assign underrun_o   = under_q;
    assign sample_cnt_o = scnt_q;

endmodule

// File: tb/tb_grad_seq_player.sv
// tb_grad_seq_player: random and directed playback checked every cycle
// against a cycle-level behavioural model of the sample player.
module tb_grad_seq_player;

    localparam int AW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [IW-1:0] interval_i = '0;
    logic          bram_en_o;
    logic [AW-1:0] bram_addr_o;
    logic [31:0]   bram_data_i = '0;
    logic [23:0]   datax_o, datay_o, dataz_o, dataz2_o;
    logic          valid_o;
    logic          busy_i = 1'b0;
    logic          running_o;
    logic          underrun_o;
    logic [IW-1:0] sample_cnt_o;

    grad_seq_player #(
        .ADDR_W     (AW),
        .INTERVAL_W (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .base_addr_i  (base_addr_i),
        .interval_i   (interval_i),
        .bram_en_o    (bram_en_o),
        .bram_addr_o  (bram_addr_o),
        .bram_data_i  (bram_data_i),
        .datax_o      (datax_o),
        .datay_o      (datay_o),
        .dataz_o      (dataz_o),
        .dataz2_o     (dataz2_o),
        .valid_o      (valid_o),
        .busy_i       (busy_i),
        .running_o    (running_o),
        .underrun_o   (underrun_o),
        .sample_cnt_o (sample_cnt_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic [31:0] rd1 = '0;

    // BRAM with a two-cycle read latency
    always @(posedge clk) begin
        rd1         <= bram_en_o ? mem[bram_addr_o] : 32'hDEAD_BEEF;
        bram_data_i <= rd1;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int vq[$];

    bit          m_run = 0, m_first = 0, m_under = 0, m_fon = 0;
    int          m_due = 0, m_fs = 0;
    logic [3:0]  m_ptr = '0, m_fa = '0;
    logic [15:0] m_cnt = '0;
    logic [23:0] m_o [4] = '{default: '0};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic prep_mem(input logic [3:0] endm);
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int s = 0; s < 4; s++) mem[4*s+3][31] = endm[s];
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance the model.
    task automatic step(input bit st, input bit sp, input bit bz);
        bit         run0, iss, en_exp;
        logic [3:0] a;
        int         n;
        start_i = st;
        stop_i  = sp;
        busy_i  = bz;
        @(negedge clk);
        run0 = m_run;
        check_eq("running", running_o, m_run);
        check_eq("underrun", underrun_o, m_under);
        check_eq("sample_cnt", sample_cnt_o, m_cnt);
        en_exp = m_fon && cyc >= m_fs && cyc < m_fs + 4;
        check_eq("bram_en", bram_en_o, en_exp);
        if (en_exp) check_eq("bram_addr", bram_addr_o, m_fa + 4'(cyc - m_fs));
        iss = 0;
        if (m_run && !sp && cyc >= m_due) begin
            if (cyc == m_due && !m_first && bz) m_under = 1;
            if (!bz) iss = 1;
        end
        if (iss) begin
            for (int k = 0; k < 4; k++) begin
                a = m_ptr + 4'(k);
                m_o[k] = mem[a][23:0];
            end
            m_cnt++;
            n = (interval_i < 8) ? 8 : int'(interval_i);
            a = m_ptr + 4'd3;
            if (mem[a][31]) begin
                m_run = 0;
            end else begin
                m_ptr   = m_ptr + 4'd4;
                m_due   = cyc + n;
                m_first = 0;
                m_fon   = 1;
                m_fs    = cyc + 1;
                m_fa    = m_ptr;
            end
        end
        check_eq("valid", valid_o, iss);
        check_eq("datax", datax_o, m_o[0]);
        check_eq("datay", datay_o, m_o[1]);
        check_eq("dataz", dataz_o, m_o[2]);
        check_eq("dataz2", dataz2_o, m_o[3]);
        if (valid_o) vq.push_back(cyc);
        if (sp) begin
            m_run = 0;
            m_fon = 0;
        end else if (st && !run0) begin
            m_run   = 1;
            m_first = 1;
            m_under = 0;
            m_cnt   = '0;
            m_ptr   = base_addr_i & 4'hC;
            m_due   = cyc + 7;
            m_fon   = 1;
            m_fs    = cyc + 1;
            m_fa    = m_ptr;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"}, bram_en_o, 0);
        check_eq({tag, "_addr"}, bram_addr_o, 0);
        check_eq({tag, "_data"}, {datax_o ^ datay_o, dataz_o | dataz2_o}, 0);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_running"}, running_o, 0);
        check_eq({tag, "_underrun"}, underrun_o, 0);
        check_eq({tag, "_cnt"}, sample_cnt_o, 0);
    endtask

    int t0;
    bit bz;

    initial begin
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // three samples, END on the third
        vq.delete(); prep_mem(4'b0100);
        base_addr_i = 4'd0; interval_i = 16'd200;
        t0 = cyc; step(1, 0, 0); idle(430);
        check_eq("basic_nvalid", vq.size(), 3);
        if (vq.size() == 3) begin
            check_eq("basic_t0", vq[0] - t0, 7);
            check_eq("basic_t1", vq[1] - t0, 207);
            check_eq("basic_t2", vq[2] - t0, 407);
        end
        check_eq("basic_cnt", sample_cnt_o, 3);

        // interval clamp, samples 1,2,3 then 0 with END
        vq.delete(); prep_mem(4'b0001);
        base_addr_i = 4'd4; interval_i = 16'd3;
        t0 = cyc; step(1, 0, 0); idle(50);
        check_eq("clamp_nvalid", vq.size(), 4);
        if (vq.size() == 4) begin
            check_eq("clamp_gap1", vq[1] - vq[0], 8);
            check_eq("clamp_gap3", vq[3] - vq[2], 8);
        end
        check_eq("clamp_underrun", underrun_o, 0);

        // busy held 50 cycles from the second expiry
        vq.delete(); prep_mem(4'b0000);
        base_addr_i = 4'd0; interval_i = 16'd20;
        t0 = cyc; step(1, 0, 0);
        for (int i = 0; i < 130; i++) step(0, 0, cyc >= t0 + 47 && cyc < t0 + 97);
        check_eq("busy_underrun", underrun_o, 1);
        step(0, 1, 0); idle(8);
        check_eq("busy_nvalid", vq.size(), 4);
        if (vq.size() == 4) begin
            check_eq("busy_late", vq[2] - t0, 97);
            check_eq("busy_next", vq[3] - vq[2], 20);
        end

        // address wrap: sample at 12..15 then 0..3 with END
        vq.delete(); prep_mem(4'b0001);
        base_addr_i = 4'd14; interval_i = 16'd10;
        t0 = cyc; step(1, 0, 0); idle(40);
        check_eq("wrap_nvalid", vq.size(), 2);
        if (vq.size() == 2) check_eq("wrap_gap", vq[1] - vq[0], 10);

        // stop during the second fetch
        vq.delete(); prep_mem(4'b0000);
        base_addr_i = 4'd0; interval_i = 16'd50;
        t0 = cyc; step(1, 0, 0); idle(8);
        step(0, 1, 0); idle(60);
        check_eq("stop_nvalid", vq.size(), 1);
        check_eq("stop_hold_x", datax_o, mem[0][23:0]);
        check_eq("stop_hold_z2", dataz2_o, mem[3][23:0]);

        // start and stop together from idle
        vq.delete();
        step(1, 1, 0); idle(12);
        check_eq("collide_nvalid", vq.size(), 0);
        check_eq("collide_running", running_o, 0);

        // asynchronous reset mid-run, then replay
        prep_mem(4'b0000);
        base_addr_i = 4'd8; interval_i = 16'd12;
        step(1, 0, 0); idle(30);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        m_run = 0; m_fon = 0; m_under = 0; m_cnt = '0;
        for (int k = 0; k < 4; k++) m_o[k] = '0;
        @(posedge clk);
        #1 rst = 1'b0; cyc++;
        idle(3);
        vq.delete();
        step(1, 0, 0); idle(20);
        check_eq("replay_nvalid", vq.size(), 2);
        step(0, 1, 0); idle(6);

        // randomized playback
        for (int r = 0; r < 40; r++) begin
            prep_mem(4'($urandom_range(0, 15)) & 4'($urandom));
            base_addr_i = 4'($urandom);
            case ($urandom_range(0, 3))
                0: interval_i = 16'($urandom_range(0, 7));
                1: interval_i = 16'd8;
                default: interval_i = 16'($urandom_range(9, 40));
            endcase
            bz = 0;
            step(1, $urandom_range(0, 9) == 0, 0);
            for (int i = 0; i < 400 && m_run; i++) begin
                if (r % 2 == 1 && $urandom_range(0, 9) == 0) bz = !bz;
                if ($urandom_range(0, 19) == 0)
                    interval_i = 16'($urandom_range(0, 30));
                step($urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0, bz);
            end
            if (m_run) step(0, 1, 0);
            idle(5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
